// File: rtl/gb_cpu_common_pkg.sv
// Shared CPU definitions: fetch-sequencer state encoding, opcode length and illegal-opcode lookups.
// GB_CPU_ILLEGAL_TRAP_EN adds the LOCKED state used to trap undefined opcodes.
package gb_cpu_common_pkg;

  localparam int unsigned GB_ADDR_W = 16;
  localparam int unsigned GB_DATA_W = 8;

  localparam logic [GB_ADDR_W-1:0] GB_RESET_PC = 16'h0000;

  typedef enum logic [2:0] {
    FETCH0 = 3'd0,
    FETCH1 = 3'd1,
    FETCH2 = 3'd2,
    ISSUE  = 3'd3
`ifdef GB_CPU_ILLEGAL_TRAP_EN
    ,
    LOCKED = 3'd4
`endif
  } fetchState_t;

  // Instruction length in bytes (1..3) as a function of the first opcode byte; CB xx is always 2.
  function automatic logic [1:0] instrLength(input logic [GB_DATA_W-1:0] byte0);
    logic [1:0] len;
    len = 2'd1;
    case (byte0)
      8'h01, 8'h11, 8'h21, 8'h31, 8'h08, 8'hC2, 8'hC3, 8'hC4, 8'hCA,
      8'hCC, 8'hCD, 8'hD2, 8'hD4, 8'hDA, 8'hDC, 8'hEA, 8'hFA:
        len = 2'd3;
      8'h06, 8'h0E, 8'h16, 8'h1E, 8'h26, 8'h2E, 8'h36, 8'h3E,
      8'h10, 8'h18, 8'h20, 8'h28, 8'h30, 8'h38,
      8'hC6, 8'hCE, 8'hD6, 8'hDE, 8'hE6, 8'hEE, 8'hF6, 8'hFE,
      8'hE0, 8'hF0, 8'hE8, 8'hF8, 8'hCB:
        len = 2'd2;
      default: len = 2'd1;
    endcase
    return len;
  endfunction

  function automatic logic isIllegalOpcode(input logic [GB_DATA_W-1:0] byte0);
    logic ill;
    ill = 1'b0;
    case (byte0)
      8'hD3, 8'hDB, 8'hDD, 8'hE3, 8'hE4, 8'hEB,
      8'hEC, 8'hED, 8'hF4, 8'hFC, 8'hFD: ill = 1'b1;
      default: ill = 1'b0;
    endcase
    return ill;
  endfunction

endpackage

// File: rtl/gb_cpu_instr_length.sv
// Combinational opcode length / illegal-opcode lookup, shareable with a future prefetch queue.
// The illegal_c output exists only with GB_CPU_ILLEGAL_TRAP_EN.
module gb_cpu_instr_length
  import gb_cpu_common_pkg::*;
(
  input  logic [GB_DATA_W-1:0] opcode,
  output logic [1:0]           len_c
`ifdef GB_CPU_ILLEGAL_TRAP_EN
  ,
  output logic                 illegal_c
`endif
);

  assign len_c = instrLength(opcode);

`ifdef GB_CPU_ILLEGAL_TRAP_EN
  assign illegal_c = isIllegalOpcode(opcode);
`endif

endmodule

// File: rtl/gb_cpu_fetch_sequencer.sv
// Instruction fetch sequencer: reads 1-3 opcode bytes at the fetch PC and hands them to the decoder.
// GB_CPU_ILLEGAL_TRAP_EN enables trapping of undefined opcodes into a LOCKED state (illegalOp port).
module gb_cpu_fetch_sequencer
  import gb_cpu_common_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  output logic                 memReq,
  output logic [GB_ADDR_W-1:0] memAddr,
  input  logic                 memAck,
  input  logic [GB_DATA_W-1:0] memData,
  input  logic                 pcLoad,
  input  logic [GB_ADDR_W-1:0] pcLoadValue,
  output logic [GB_DATA_W-1:0] opcodeByte0,
  output logic [GB_DATA_W-1:0] opcodeByte1,
  output logic [GB_DATA_W-1:0] opcodeByte2,
  output logic [GB_ADDR_W-1:0] instrPc,
  output logic                 instrValid,
  input  logic                 instrReady
`ifdef GB_CPU_ILLEGAL_TRAP_EN
  ,
  output logic                 illegalOp
`endif
);

  fetchState_t          state_q, state_d;
  logic [GB_ADDR_W-1:0] pc_q, pc_d;
  logic [GB_ADDR_W-1:0] instr_pc_q, instr_pc_d;
  logic [GB_DATA_W-1:0] byte0_q, byte0_d;
  logic [GB_DATA_W-1:0] byte1_q, byte1_d;
  logic [GB_DATA_W-1:0] byte2_q, byte2_d;

  logic [GB_DATA_W-1:0] lookup_byte_c;
  logic [1:0]           len_c;
  logic [GB_ADDR_W-1:0] pc_inc_c;
  logic                 fetching_c;

  // Length is decided from the incoming byte in FETCH0 and from the captured byte afterwards.
  assign lookup_byte_c = (state_q == FETCH0) ? memData : byte0_q;
  assign pc_inc_c      = pc_q + GB_ADDR_W'(1);

`ifdef GB_CPU_ILLEGAL_TRAP_EN
  logic illegal_c;

  gb_cpu_instr_length u_len (
    .opcode    (lookup_byte_c),
    .len_c     (len_c),
    .illegal_c (illegal_c)
  );
`else
  gb_cpu_instr_length u_len (
    .opcode (lookup_byte_c),
    .len_c  (len_c)
  );
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= FETCH0;
      pc_q       <= GB_RESET_PC;
      instr_pc_q <= GB_RESET_PC;
      byte0_q    <= '0;
      byte1_q    <= '0;
      byte2_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_pc_q <= instr_pc_d;
      byte0_q    <= byte0_d;
      byte1_q    <= byte1_d;
      byte2_q    <= byte2_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_pc_d = instr_pc_q;
    byte0_d    = byte0_q;
    byte1_d    = byte1_q;
    byte2_d    = byte2_q;

    // A PC reload wins over everything, including an ack arriving in the same cycle.
    if (pcLoad) begin
      pc_d    = pcLoadValue;
      state_d = FETCH0;
    end else begin
      case (state_q)
        FETCH0: begin
          if (memAck) begin
            byte0_d = memData;
            pc_d    = pc_inc_c;
            state_d = (len_c > 2'd1) ? FETCH1 : ISSUE;
`ifdef GB_CPU_ILLEGAL_TRAP_EN
            if (illegal_c) state_d = LOCKED;
`endif
          end
        end
        FETCH1: begin
          if (memAck) begin
            byte1_d = memData;
            pc_d    = pc_inc_c;
            state_d = (len_c == 2'd3) ? FETCH2 : ISSUE;
          end
        end
        FETCH2: begin
          if (memAck) begin
            byte2_d = memData;
            pc_d    = pc_inc_c;
            state_d = ISSUE;
          end
        end
        ISSUE: begin
          if (instrReady) state_d = FETCH0;
        end
`ifdef GB_CPU_ILLEGAL_TRAP_EN
        LOCKED: state_d = state_q;
`endif
        default: state_d = FETCH0;
      endcase
    end

    // Starting a new instruction: trailing bytes read zero and instrPc tracks the fetch address.
    if (state_d == FETCH0) begin
      byte1_d    = '0;
      byte2_d    = '0;
      instr_pc_d = pc_d;
    end
  end

  assign fetching_c  = (state_q == FETCH0) || (state_q == FETCH1) || (state_q == FETCH2);
  assign memReq      = fetching_c && !reset;
  assign memAddr     = pc_q;
  assign opcodeByte0 = byte0_q;
  assign opcodeByte1 = byte1_q;
  assign opcodeByte2 = byte2_q;
  assign instrPc     = instr_pc_q;
  assign instrValid  = (state_q == ISSUE);

`ifdef GB_CPU_ILLEGAL_TRAP_EN
  assign illegalOp = (state_q == LOCKED);
`endif

endmodule

// File: tb/tb_gb_cpu_fetch_sequencer.sv
// Bench for gb_cpu_fetch_sequencer: memory responder with wait states, instruction-level model, directed scenarios.
module tb_gb_cpu_fetch_sequencer;

  logic        clk;
  logic        reset;
  logic        memReq;
  logic [15:0] memAddr;
  logic        memAck;
  logic [7:0]  memData;
  logic        pcLoad;
  logic [15:0] pcLoadValue;
  logic [7:0]  opcodeByte0, opcodeByte1, opcodeByte2;
  logic [15:0] instrPc;
  logic        instrValid;
  logic        instrReady;
`ifdef GB_CPU_ILLEGAL_TRAP_EN
  logic        illegalOp;
`endif

  gb_cpu_fetch_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .memReq      (memReq),
    .memAddr     (memAddr),
    .memAck      (memAck),
    .memData     (memData),
    .pcLoad      (pcLoad),
    .pcLoadValue (pcLoadValue),
    .opcodeByte0 (opcodeByte0),
    .opcodeByte1 (opcodeByte1),
    .opcodeByte2 (opcodeByte2),
    .instrPc     (instrPc),
    .instrValid  (instrValid),
    .instrReady  (instrReady)
`ifdef GB_CPU_ILLEGAL_TRAP_EN
    ,
    .illegalOp   (illegalOp)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- memory and responder ----------------
  logic [7:0] mem [0:65535];
  int         wait_cfg = 0;
  int         wcnt = 0;
  logic       req_seen = 1'b0;
  logic [15:0] req_addr = 16'h0000;

  initial begin
    memAck  = 1'b0;
    memData = 8'hEE;
  end

  always @(negedge clk) begin
    if (memReq) begin
      if (!req_seen || memAddr != req_addr) begin
        wcnt     = 0;
        req_addr = memAddr;
        req_seen = 1'b1;
      end
      if (wcnt >= wait_cfg) begin
        memAck   = 1'b1;
        memData  = mem[memAddr];
        req_seen = 1'b0;
      end else begin
        memAck  = 1'b0;
        memData = 8'hEE;
        wcnt++;
      end
    end else begin
      memAck   = 1'b0;
      memData  = 8'hEE;
      req_seen = 1'b0;
    end
  end

  // ---------------- instruction-level model ----------------
  typedef struct packed {
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [7:0]  b2;
    logic [15:0] pc;
    logic [1:0]  len;
  } minstr_t;

  typedef struct {
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [7:0]  b2;
    logic [15:0] pc;
    int          cyc;
  } issue_t;

  issue_t log_q[$];

  function automatic int model_len(input logic [7:0] op);
    logic [7:0] l3 [0:16] = '{8'h01, 8'h11, 8'h21, 8'h31, 8'h08, 8'hC2, 8'hC3, 8'hC4, 8'hCA,
                              8'hCC, 8'hCD, 8'hD2, 8'hD4, 8'hDA, 8'hDC, 8'hEA, 8'hFA};
    logic [7:0] l2 [0:26] = '{8'h06, 8'h0E, 8'h16, 8'h1E, 8'h26, 8'h2E, 8'h36, 8'h3E,
                              8'h10, 8'h18, 8'h20, 8'h28, 8'h30, 8'h38, 8'hC6, 8'hCE,
                              8'hD6, 8'hDE, 8'hE6, 8'hEE, 8'hF6, 8'hFE, 8'hE0, 8'hF0,
                              8'hE8, 8'hF8, 8'hCB};
    foreach (l3[i]) if (l3[i] == op) return 3;
    foreach (l2[i]) if (l2[i] == op) return 2;
    return 1;
  endfunction

  function automatic minstr_t model_instr(input logic [15:0] pc);
    minstr_t     m;
    logic [15:0] a1, a2;
    int          n;
    a1   = pc + 16'd1;
    a2   = pc + 16'd2;
    n    = model_len(mem[pc]);
    m.b0 = mem[pc];
    m.b1 = (n > 1) ? mem[a1] : 8'h00;
    m.b2 = (n > 2) ? mem[a2] : 8'h00;
    m.pc = pc;
    m.len = 2'(n);
    return m;
  endfunction

  // ---------------- per-cycle compare process ----------------
  logic [15:0] model_pc = 16'h0000;
  int          cyc = 0;
  int          last_ack_cyc = -10;
  logic        p_valid = 1'b0, p_ready = 1'b0, p_load = 1'b0, p_reset = 1'b1;
  logic        p_req = 1'b0, p_ack = 1'b0;
  logic [15:0] p_addr = 16'h0000, p_pc = 16'h0000;
  logic [7:0]  p_b0 = 8'h00, p_b1 = 8'h00, p_b2 = 8'h00;

  always @(negedge clk) begin
    minstr_t e;
    issue_t  it;
    #2;
    cyc++;
    if (reset) begin
      check("rst_memreq", 64'(memReq), 64'(0));
      model_pc = 16'h0000;
    end else begin
      if (p_valid && !p_ready && !p_load && !p_reset)
        check("issue_hold", {instrValid, opcodeByte0, opcodeByte1, opcodeByte2, instrPc},
              {1'b1, p_b0, p_b1, p_b2, p_pc});
      if (p_req && !p_ack && !p_load && !p_reset)
        check("addr_hold", {memReq, memAddr}, {1'b1, p_addr});
      check("valid_vs_req", 64'(instrValid && memReq), 64'(0));
      if (instrValid && !p_valid)
        check("issue_latency", 64'(cyc - last_ack_cyc), 64'(1));
      if (memReq && memAck && !pcLoad) last_ack_cyc = cyc;
      if (instrValid && instrReady) begin
        e = model_instr(model_pc);
        check("issue_model", {opcodeByte0, opcodeByte1, opcodeByte2, instrPc},
              {e.b0, e.b1, e.b2, e.pc});
        it.b0 = opcodeByte0; it.b1 = opcodeByte1; it.b2 = opcodeByte2;
        it.pc = instrPc; it.cyc = cyc;
        log_q.push_back(it);
        model_pc = model_pc + 16'(e.len);
      end
      if (pcLoad) model_pc = pcLoadValue;
    end
    p_valid = instrValid; p_ready = instrReady; p_load = pcLoad; p_reset = reset;
    p_req = memReq; p_ack = memAck; p_addr = memAddr; p_pc = instrPc;
    p_b0 = opcodeByte0; p_b1 = opcodeByte1; p_b2 = opcodeByte2;
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_issues(input int n, input int bound);
    int k;
    k = 0;
    while (log_q.size() < n && k < bound) begin
      @(negedge clk);
      #3;
      k++;
    end
    if (log_q.size() < n) check("issue_timeout", 64'(log_q.size()), 64'(n));
  endtask

  task automatic restart(input logic [15:0] pc, output int start_cyc);
    @(negedge clk);
    pcLoad      = 1'b1;
    pcLoadValue = pc;
    @(negedge clk);
    pcLoad = 1'b0;
    log_q.delete();
    start_cyc = cyc + 1;
    check("load_addr", {memReq, memAddr}, {1'b1, pc});
  endtask

  task automatic check_log(input string name, input int idx, input logic [39:0] exp);
    if (log_q.size() > idx)
      check(name, {log_q[idx].b0, log_q[idx].b1, log_q[idx].b2, log_q[idx].pc}, exp);
    else
      check({name, "_missing"}, 64'(log_q.size()), 64'(idx + 1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    int start;
    int k;
    logic found;

    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    reset = 1'b1; pcLoad = 1'b0; pcLoadValue = 16'h0000; instrReady = 1'b1;

    mem[16'h0000] = 8'h00; mem[16'h0001] = 8'h3E; mem[16'h0002] = 8'h42;
    mem[16'h0003] = 8'hC3; mem[16'h0004] = 8'h34; mem[16'h0005] = 8'h12;

    repeat (3) @(negedge clk);
    check("rst_state", {opcodeByte0, opcodeByte1, opcodeByte2, instrPc, instrValid, memReq}, 64'(0));

    // S1: zero-wait stream 00 / 3E 42 / C3 34 12
    @(posedge clk);
    #1 reset = 1'b0;
    start = cyc + 1;
    log_q.delete();
    @(negedge clk);
    check("first_req", {memReq, memAddr}, {1'b1, 16'h0000});
    wait_issues(3, 40);
    check_log("s1_i0", 0, {8'h00, 8'h00, 8'h00, 16'h0000});
    check_log("s1_i1", 1, {8'h3E, 8'h42, 8'h00, 16'h0001});
    check_log("s1_i2", 2, {8'hC3, 8'h34, 8'h12, 16'h0003});
    if (log_q.size() >= 3) begin
      check("s1_lat0", 64'(log_q[0].cyc - start), 64'(1));
      check("s1_gap1", 64'(log_q[1].cyc - log_q[0].cyc), 64'(3));
      check("s1_gap2", 64'(log_q[2].cyc - log_q[1].cyc), 64'(4));
    end

    // S2: CB 7C with two wait states per byte
    mem[16'h0200] = 8'hCB; mem[16'h0201] = 8'h7C;
    @(posedge clk) wait_cfg = 2;
    restart(16'h0200, start);
    wait_issues(1, 30);
    check_log("s2_cb", 0, {8'hCB, 8'h7C, 8'h00, 16'h0200});
    if (log_q.size() >= 1) check("s2_lat", 64'(log_q[0].cyc - start), 64'(6));

    // S3: execute stalls for five cycles in ISSUE
    mem[16'h0300] = 8'h3E; mem[16'h0301] = 8'h99;
    @(posedge clk) wait_cfg = 0;
    @(negedge clk) instrReady = 1'b0;
    restart(16'h0300, start);
    k = 0;
    while (!instrValid && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("s3_valid", 64'(instrValid), 64'(1));
    check("s3_bytes", {opcodeByte0, opcodeByte1, opcodeByte2, instrPc}, {8'h3E, 8'h99, 8'h00, 16'h0300});
    for (int i = 0; i < 5; i++) begin
      check("s3_stall", {instrValid, memReq}, {1'b1, 1'b0});
      @(negedge clk);
    end
    instrReady = 1'b1;
    @(negedge clk);
    check("s3_resume", {memReq, memAddr, instrValid}, {1'b1, 16'h0302, 1'b0});
    check_log("s3_issue", 0, {8'h3E, 8'h99, 8'h00, 16'h0300});

    // S4: PC reload while fetching the second byte of a 3-byte instruction
    mem[16'h0400] = 8'h01; mem[16'h0401] = 8'hAA; mem[16'h0402] = 8'hBB;
    mem[16'h0150] = 8'h3E; mem[16'h0151] = 8'h77;
    @(posedge clk) wait_cfg = 1;
    restart(16'h0400, start);
    found = 1'b0;
    k = 0;
    while (!found && k < 20) begin
      @(negedge clk);
      if (memReq && memAddr == 16'h0401) found = 1'b1;
      k++;
    end
    check("s4_in_fetch1", 64'(found), 64'(1));
    pcLoad = 1'b1; pcLoadValue = 16'h0150;
    @(negedge clk);
    pcLoad = 1'b0;
    log_q.delete();
    check("s4_reload_addr", {memReq, memAddr}, {1'b1, 16'h0150});
    wait_issues(1, 30);
    check_log("s4_issue", 0, {8'h3E, 8'h77, 8'h00, 16'h0150});

    // S5: PC wraps from FFFF to 0000 inside an instruction
    mem[16'hFFFF] = 8'h3E; mem[16'h0000] = 8'h55;
    @(posedge clk) wait_cfg = 0;
    restart(16'hFFFF, start);
    wait_issues(2, 30);
    check_log("s5_wrap", 0, {8'h3E, 8'h55, 8'h00, 16'hFFFF});
    check_log("s5_next", 1, {8'h3E, 8'h42, 8'h00, 16'h0001});

    // S6: undefined opcode D3
    mem[16'h0500] = 8'hD3;
    restart(16'h0500, start);
`ifdef GB_CPU_ILLEGAL_TRAP_EN
    repeat (4) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check("s6_locked", {illegalOp, memReq, instrValid}, {1'b1, 1'b0, 1'b0});
      @(negedge clk);
    end
    check("s6_no_issue", 64'(log_q.size()), 64'(0));
    restart(16'h0000, start);
    check("s6_unlocked", 64'(illegalOp), 64'(0));
    wait_issues(1, 20);
    check_log("s6_recover", 0, {8'h55, 8'h00, 8'h00, 16'h0000});
`else
    wait_issues(2, 20);
    check_log("s6_d3", 0, {8'hD3, 8'h00, 8'h00, 16'h0500});
    check_log("s6_next", 1, {8'h00, 8'h00, 8'h00, 16'h0501});
`endif

    // Reset in the middle of a fetch
    @(posedge clk) wait_cfg = 2;
    restart(16'h0003, start);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midreset", {memReq, instrValid, instrPc, opcodeByte1}, 64'(0));
    @(posedge clk);
    #1 reset = 1'b0;
    wait_cfg = 0;
    @(negedge clk);
    check("midreset_pc", {memReq, memAddr}, {1'b1, 16'h0000});

    repeat (10) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gb_cpu_fetch_sequencer.md
# gb_cpu_fetch_sequencer

Instruction fetch sequencer feeding `gb_cpu_decoder`. Pulls 1–3 opcode bytes from the memory bus via a req/ack handshake, starting at the program counter, and determines instruction length from byte 0 (including the `$CB` prefix). It presents the assembled `opcodeByte0/1/2` to the decoder with a valid/ready handshake toward execute. It owns the fetch PC and accepts PC reloads from execute for jumps, calls, returns and interrupts.

## Interface
- No parameters.
- `clk  in  1`: single clock.
- `reset  in  1`: synchronous, active-high.
- `memReq  out  1`: read request; held until `memAck`.
- `memAddr  out  16`: read address, equal to the fetch PC.
- `memAck  in  1`: read complete; `memData` is valid in the same cycle.
- `memData  in  8`: read data.
- `pcLoad  in  1`: reload the fetch PC; aborts any fetch in progress.
- `pcLoadValue  in  16`: new PC.
- `opcodeByte0/1/2  out  8 each`: instruction bytes to the decoder; unfetched bytes read `8'h00`.
- `instrPc  out  16`: address of `opcodeByte0`.
- `instrValid  out  1`: instruction bytes are stable and valid.
- `instrReady  in  1`: execute accepts the instruction.
- `illegalOp  out  1`: only with `GB_CPU_ILLEGAL_TRAP_EN` (see Configuration).

## Operation
- States: `FETCH0`, `FETCH1`, `FETCH2`, `ISSUE`, `LOCKED` (`LOCKED` exists only with the macro).
- Reset value of every output:
  - state `FETCH0`, PC `16'h0000`
  - opcode bytes `8'h00`, `instrPc` `16'h0000`
  - `instrValid` 0, `illegalOp` 0
  - `memReq` forced 0 while `reset` is high.
- `memReq = (state ∈ FETCH0/1/2) && !reset`. `memAddr` = PC.
- Byte capture: on a `FETCHn` cycle with `memAck`=1, capture `memData` into `opcodeByte n` and increment PC.
  - PC increment is modulo 2^16: `16'hFFFF` → `16'h0000`.
- Entering `FETCH0` clears bytes 1/2 and latches `instrPc` = PC.
- Length from byte 0:
  - **3 bytes**: `01 11 21 31 08 C2 C3 C4 CA CC CD D2 D4 DA DC EA FA`.
  - **2 bytes**: `06 0E 16 1E 26 2E 36 3E 10 18 20 28 30 38 C6 CE D6 DE E6 EE F6 FE E0 F0 E8 F8 CB`.
  - **1 byte**: all others.
  - `CB xx` is always exactly 2 bytes.
- Transitions:
  - `FETCH0` +ack → `FETCH1` if len > 1, else `ISSUE`.
  - `FETCH1` +ack → `FETCH2` if len = 3, else `ISSUE`.
  - `FETCH2` +ack → `ISSUE`.
  - `ISSUE`: `instrValid`=1. On `instrReady` → `FETCH0`.
- Handshake rules:
  - Bytes and `instrPc` are stable while `instrValid` && !`instrReady`.
  - `memAddr` is stable while `memReq` && !`memAck`.
- `pcLoad` (any state, highest priority):
  - PC ← `pcLoadValue`; next state `FETCH0`.
  - Any partial instruction is discarded; a concurrent `memAck` is ignored.
  - In `ISSUE` with `instrReady` in the same cycle: the handshake completes, and the next fetch starts at `pcLoadValue`.
  - In `ISSUE` without `instrReady`: the instruction is dropped (`instrValid` falls).
- `reset` mid-fetch: everything returns to reset values at the next edge; an in-flight ack is ignored.

## Timing
- Zero-wait memory (`memAck` tied 1): issue latency is n cycles for an n-byte instruction.
  - 1-byte: `memReq` in cycle 0, `instrValid` in cycle 1.
- Each wait state adds one cycle per byte.
- Sustained rate with `instrReady`=1 and `memAck`=1: one instruction per (len+1) cycles.
- `instrValid` is registered (state decode); no combinational path from `instrReady` to `memReq` within a cycle, other than through the state register.
- `pcLoad` takes effect at the next edge: `memAddr` = `pcLoadValue` in the following cycle.

## Configuration
- `GB_CPU_ILLEGAL_TRAP_EN` defined:
  - Byte 0 ∈ {`D3 DB DD E3 E4 EB EC ED F4 FC FD`} → state `LOCKED` instead of `ISSUE`.
  - In `LOCKED`: `illegalOp`=1, `memReq`=0, `instrValid`=0.
  - Exit only via `reset` or `pcLoad`.
- Undefined: these opcodes are ordinary 1-byte instructions, the `illegalOp` port and `LOCKED` are absent.

## Structure
- `gb_cpu_common_pkg` additions:
  - `fetchState_t` enum.
  - `instrLength(byte0)` function returning 2-bit length.
  - `isIllegalOpcode(byte0)` function.
  - `GB_RESET_PC` = `16'h0000`.
- One sub-module: `gb_cpu_instr_length`, a combinational length/illegal lookup wrapping the package functions, so it can be shared with a future prefetch queue.

## Test plan
- Zero-wait memory holding `00 3E 42 C3 34 12` from `0000`, `instrReady`=1 → issues:
  - `{00,00,00}` @`0000`
  - `{3E,42,00}` @`0001`
  - `{C3,34,12}` @`0003`
  - each `instrValid` one cycle after the last byte ack.
- `CB 7C` with `memAck` delayed 2 cycles per byte → `instrValid` after 6 cycles; bytes `{CB,7C,00}`; `memAddr` stable during the waits.
- `instrReady`=0 for 5 cycles in `ISSUE` → `instrValid` and bytes held; no `memReq`; fetch resumes at the next PC after ready.
- `pcLoad`=`16'h0150` during `FETCH1` of `01 xx xx` → partial instruction discarded; next `memAddr`=`0150`; next issued `instrPc`=`0150`.
- PC at `FFFF` holding `3E`, `0000` holding `55` → issues `{3E,55,00}` with `instrPc`=`FFFF`.
- With the macro: byte `D3` → `illegalOp`=1, `memReq`=0 indefinitely; `pcLoad`=`0000` recovers. Without the macro: `D3` issues as a 1-byte instruction.
